count_connected_param_core: RTL and testbench

COUNT_CONNECTED_PARAM_CORE -- requirements
Module: count_connected_param_core

---
 rtl/cc_pkg.sv | 16 +
 rtl/cc_monotonize.sv | 42 ++++
 rtl/count_connected_param_core.sv | 106 ++++++++++
 tb/tb_count_connected_param_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared types and helpers for the connected-component counting core.
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEED    = 2'd1,
    EXPLORE = 2'd2,
    DONE    = 2'd3
  } ccState_e;

  // One graph bit per variable subset.
  function automatic int graphWidth(input int vars);
    return 1 << vars;
  endfunction

endpackage

// File: rtl/cc_monotonize.sv
// Upward (DIR_UP=1) or downward (DIR_UP=0) closure of a subset-indexed bit vector,
// built as a VARS-stage butterfly: stage s merges each index with its bit-s neighbour.
module cc_monotonize
  import cc_pkg::*;
#(
  parameter int VARS   = 7,
  parameter bit DIR_UP = 1'b1
) (
  input  logic [graphWidth(VARS)-1:0] vecIn,
  output logic [graphWidth(VARS)-1:0] vecOut
);

  localparam int GW = graphWidth(VARS);

  logic [GW-1:0]   cur;
  logic [GW-1:0]   prv;
  logic [VARS-1:0] kIdx;
  logic [VARS-1:0] bitS;

  always_comb begin
    cur  = vecIn;
    prv  = '0;
    kIdx = '0;
    bitS = '0;
    for (int s = 0; s < VARS; s++) begin
      prv  = cur;
      bitS = VARS'(1) << s;
      for (int k = 0; k < GW; k++) begin
        kIdx = VARS'(k);
        if (DIR_UP) begin
          // k gains whatever its subset without bit s holds
          if ((kIdx & bitS) != '0) cur[kIdx] = prv[kIdx] | prv[kIdx & ~bitS];
        end else begin
          if ((kIdx & bitS) == '0) cur[kIdx] = prv[kIdx] | prv[kIdx | bitS];
        end
      end
    end
  end

  assign vecOut = cur;

endmodule

// File: rtl/count_connected_param_core.sv
// Counts connected components of a subset-comparability graph, one job at a time,
// by repeatedly seeding on the lowest leftover bit and growing it to a fixpoint.
module count_connected_param_core
  import cc_pkg::*;
#(
  parameter int VARS    = 7,
  parameter int COUNT_W = 6,
  parameter int EXTRA_W = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [graphWidth(VARS)-1:0] graphIn,
  input  logic [COUNT_W-1:0]          startingConnectCountIn,
  input  logic [EXTRA_W-1:0]          extraDataIn,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [COUNT_W-1:0]          connectCount,
  output logic                        countOverflow,
  output logic [EXTRA_W-1:0]          extraDataOut
);

  localparam int GW = graphWidth(VARS);
  localparam logic [COUNT_W-1:0] CMAX = '1;

  ccState_e           state, stateNext;
  logic [GW-1:0]      leftover;
  logic [GW-1:0]      extended;
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic [EXTRA_W-1:0] extra;

  logic [GW-1:0] upVec, downVec, nextExt, seedBit;

  cc_monotonize #(.VARS(VARS), .DIR_UP(1'b1)) uUp (
    .vecIn (extended),
    .vecOut(upVec)
  );

  cc_monotonize #(.VARS(VARS), .DIR_UP(1'b0)) uDown (
    .vecIn (upVec & leftover),
    .vecOut(downVec)
  );

  assign nextExt = leftover & downVec;
  // isolate the lowest set bit
  assign seedBit = leftover & (~leftover + GW'(1));

  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    case (state)
      IDLE: begin
        inReady = !rst;
        if (inValid) stateNext = SEED;
      end
      SEED:    stateNext = (leftover == '0) ? DONE : EXPLORE;
      EXPLORE: if (nextExt == extended) stateNext = SEED;
      DONE: begin
        outValid = !rst;
        if (outReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      leftover <= '0;
      extended <= '0;
      count    <= '0;
      overflow <= 1'b0;
      extra    <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (inValid) begin
          leftover <= graphIn;
          extended <= '0;
          count    <= startingConnectCountIn;
          overflow <= 1'b0;
          extra    <= extraDataIn;
        end
        SEED: if (leftover != '0) begin
          extended <= seedBit;
          if (count == CMAX) overflow <= 1'b1;
          else               count    <= count + COUNT_W'(1);
        end
        EXPLORE: begin
          // fixpoint reached: retire the whole component
          if (nextExt == extended) leftover <= leftover & ~extended;
          else                     extended <= nextExt;
        end
        default: ;
      endcase
    end
  end

  assign connectCount  = count;
  assign countOverflow = overflow;
  assign extraDataOut  = extra;

endmodule

// File: tb/tb_count_connected_param_core.sv
// Bench for count_connected_param_core: three instances (VARS 7/3/4), union-find model,
// per-cycle output checker, directed vectors plus random graphs.
module tb_count_connected_param_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0]        inValid, outReady;
  logic [2:0][127:0] graph;
  logic [2:0][5:0]   startIn;
  logic [2:0][9:0]   extraIn;

  logic ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [5:0] c0, c2;
  logic [1:0] c1;
  logic [9:0] x0, x1, x2;

  logic [2:0] inReady, outValid, ovf;
  logic [5:0] cnt [3];
  logic [9:0] xo  [3];

  assign inReady  = {ir2, ir1, ir0};
  assign outValid = {ov2, ov1, ov0};
  assign ovf      = {of2, of1, of0};
  always_comb begin
    cnt[0] = c0; cnt[1] = {4'b0, c1}; cnt[2] = c2;
    xo[0]  = x0; xo[1]  = x1;         xo[2]  = x2;
  end

  count_connected_param_core #(.VARS(7), .COUNT_W(6), .EXTRA_W(10)) dut0 (
    .clk(clk), .rst(rst), .inValid(inValid[0]), .inReady(ir0), .graphIn(graph[0]),
    .startingConnectCountIn(startIn[0]), .extraDataIn(extraIn[0]), .outValid(ov0),
    .outReady(outReady[0]), .connectCount(c0), .countOverflow(of0), .extraDataOut(x0));

  count_connected_param_core #(.VARS(3), .COUNT_W(2), .EXTRA_W(10)) dut1 (
    .clk(clk), .rst(rst), .inValid(inValid[1]), .inReady(ir1), .graphIn(graph[1][7:0]),
    .startingConnectCountIn(startIn[1][1:0]), .extraDataIn(extraIn[1]), .outValid(ov1),
    .outReady(outReady[1]), .connectCount(c1), .countOverflow(of1), .extraDataOut(x1));

  count_connected_param_core #(.VARS(4), .COUNT_W(6), .EXTRA_W(10)) dut2 (
    .clk(clk), .rst(rst), .inValid(inValid[2]), .inReady(ir2), .graphIn(graph[2][15:0]),
    .startingConnectCountIn(startIn[2]), .extraDataIn(extraIn[2]), .outValid(ov2),
    .outReady(outReady[2]), .connectCount(c2), .countOverflow(of2), .extraDataOut(x2));

  int checks = 0, errors = 0;
  bit         pending  [3];
  int         expCount [3];
  bit         expOvf   [3];
  logic [9:0] expExtra [3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Union-find over set bits; adjacency is subset comparability.
  function automatic int cc(input logic [127:0] g, input int n);
    int par [128];
    int comps, ra, rb;
    comps = 0;
    for (int i = 0; i < n; i++) par[i] = i;
    for (int a = 0; a < n; a++) begin
      if (!g[a]) continue;
      for (int b = 0; b < a; b++) begin
        if (!g[b] || !(((a & b) == a) || ((a & b) == b))) continue;
        ra = a; while (par[ra] != ra) ra = par[ra];
        rb = b; while (par[rb] != rb) rb = par[rb];
        if (ra != rb) par[ra] = rb;
      end
    end
    for (int i = 0; i < n; i++) if (g[i] && par[i] == i) comps++;
    return comps;
  endfunction

  // Checker: whenever a result is offered it must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (outValid[d]) begin
          if (!pending[d]) begin
            checks++; errors++;
            $display("FAIL spurious outValid on dut%0d", d);
          end else begin
            chk($sformatf("dut%0d connectCount", d), 32'(cnt[d]), 32'(expCount[d]));
            chk($sformatf("dut%0d countOverflow", d), 32'(ovf[d]), 32'(expOvf[d]));
            chk($sformatf("dut%0d extraDataOut", d), 32'(xo[d]), 32'(expExtra[d]));
          end
        end
      end
    end
  end

  task automatic job(input int d, input logic [127:0] g, input int s, input int x,
                     input int hold, input bit pokeNew, output int lat);
    int comps, mx, vars;
    vars = (d == 0) ? 7 : ((d == 1) ? 3 : 4);
    mx   = (d == 1) ? 3 : 63;
    comps = cc(g, 1 << vars);
    lat = 0;
    @(negedge clk);
    chk($sformatf("dut%0d inReady idle", d), 32'(inReady[d]), 32'd1);
    if (!inReady[d]) return;
    expCount[d] = (s + comps > mx) ? mx : s + comps;
    expOvf[d]   = (s + comps > mx);
    expExtra[d] = 10'(x);
    pending[d]  = 1'b1;
    graph[d] = g; startIn[d] = 6'(s); extraIn[d] = 10'(x); inValid[d] = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      inValid[d] = 1'b0;
    end while (!outValid[d] && lat < 3000);
    if (!outValid[d]) begin
      chk($sformatf("dut%0d result timeout", d), 32'd0, 32'd1);
      pending[d] = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (pokeNew) begin inValid[d] = 1'b1; graph[d] = ~g; end
      @(negedge clk);
      chk($sformatf("dut%0d inReady while held", d), 32'(inReady[d]), 32'd0);
    end
    outReady[d] = 1'b1;
    @(negedge clk);
    outReady[d] = 1'b0; inValid[d] = 1'b0; pending[d] = 1'b0;
    chk($sformatf("dut%0d inReady after release", d), 32'(inReady[d]), 32'd1);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [127:0] g, chain;
    int lat;
    rst = 1'b1; inValid = '0; outReady = '0; graph = '0; startIn = '0; extraIn = '0;
    for (int d = 0; d < 3; d++) pending[d] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset inReady", 32'(inReady), 32'd0);
    chk("reset outValid", 32'(outValid), 32'd0);
    chk("reset connectCount", 32'(cnt[0]), 32'd0);
    chk("reset countOverflow", 32'(ovf), 32'd0);
    chk("reset extraDataOut", 32'(xo[0]), 32'd0);
    rst = 1'b0;
    #1;
    chk("inReady after reset", 32'(inReady), 32'd7);

    // pin the model against hand-derived counts
    g = '0; g[1] = 1; g[2] = 1;             chk("model {1,2}", cc(g, 128), 2);
    g[3] = 1;                               chk("model {1,2,3}", cc(g, 128), 1);
    g = '0; g[3] = 1; g[5] = 1; g[6] = 1;   chk("model {3,5,6}", cc(g, 8), 3);

    // empty graph: result two cycles after accept
    job(0, 128'd0, 5, 'h2A, 0, 0, lat);
    chk("latency empty", 32'(lat), 32'd2);
    g = '0; g[1] = 1; g[2] = 1;
    job(0, g, 0, 'h11, 0, 0, lat);
    chk("latency {1,2}", 32'(lat), 32'd6);
    g[3] = 1;
    job(0, g, 0, 'h12, 0, 0, lat);
    chk("latency {1,2,3}", 32'(lat), 32'd5);
    g = '0; g[0] = 1; g[127] = 1;
    job(0, g, 0, 'h13, 0, 0, lat);
    chk("latency {0,127}", 32'(lat), 32'd5);

    // antichain saturates a 2-bit counter
    g = '0; g[3] = 1; g[5] = 1; g[6] = 1;
    job(1, g, 1, 'h14, 0, 0, lat);
    chk("latency antichain", 32'(lat), 32'd8);

    // backpressure with a competing offer that must be ignored
    g = '0; g[1] = 1; g[2] = 1; g[3] = 1;
    job(0, g, 7, 'h155, 5, 1, lat);
    repeat (3) @(negedge clk);
    chk("ignored job not taken", 32'(inReady[0]), 32'd1);

    // reset pulse while exploring a chain
    chain = '0;
    chain[0] = 1; chain[1] = 1; chain[3] = 1; chain[7] = 1;
    chain[15] = 1; chain[31] = 1; chain[63] = 1; chain[127] = 1;
    graph[0] = chain; startIn[0] = 6'd9; extraIn[0] = 10'h0F0; inValid[0] = 1'b1;
    @(negedge clk); inValid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("inReady during reset", 32'(inReady[0]), 32'd0);
    chk("outValid during reset", 32'(outValid[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("inReady after mid-job reset", 32'(inReady[0]), 32'd1);
    chk("count cleared by reset", 32'(cnt[0]), 32'd0);
    repeat (4) @(negedge clk);
    job(0, chain, 3, 'h3FF, 0, 0, lat);
    chk("latency chain", 32'(lat), 32'd5);

    // random graphs of mixed density
    for (int i = 0; i < 800 && errors < 50; i++) begin
      g = {$urandom, $urandom, $urandom, $urandom};
      if (i % 3 == 1) g &= {$urandom, $urandom, $urandom, $urandom};
      if (i % 3 == 2) g &= {$urandom, $urandom, $urandom, $urandom} &
                           {$urandom, $urandom, $urandom, $urandom} &
                           {$urandom, $urandom, $urandom, $urandom};
      job(0, g, int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 2)), 0, lat);
    end
    for (int i = 0; i < 800 && errors < 50; i++) begin
      g = {96'd0, $urandom};
      if (i % 2 == 1) g &= {96'd0, $urandom};
      g &= 128'hFFFF;
      job(2, g, int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)), 0, 0, lat);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
